// File: rtl/itof_share_ctrl_pkg.sv
// Shared definitions for the shared int-to-float conversion pipeline (package fcvt_pkg).
package fcvt_pkg;

  localparam logic [31:0] FCVT_NEG_2_31 = 32'hCF000000;
  localparam int FCVT_ID_MAX_W  = 3;
  localparam int FCVT_TAG_MAX_W = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Result record at its widest; blocks carry narrower per-instance copies.
  typedef struct packed {
    logic [31:0]               data;
    logic [FCVT_ID_MAX_W-1:0]  id;
    logic [FCVT_TAG_MAX_W-1:0] tag;
  } fcvt_res_t;

endpackage

// File: rtl/itof.sv
// Combinational signed int32 to IEEE-754 single converter, truncating toward zero.
module itof
  import fcvt_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] f
);

  logic        sgn;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  msb;
  logic [7:0]  expo;

  always_comb begin
    sgn = a[31];
    mag = sgn ? (~a + 32'd1) : a;
    msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    // leading one lands on bit 31; bits [30:8] become the mantissa
    norm = mag << (5'd31 - msb);
    expo = 8'd127 + {3'b000, msb};
    if (a == 32'd0)
      f = 32'd0;
    else if (a == 32'h80000000)
      f = FCVT_NEG_2_31;
    else
      f = {sgn, expo, norm[30:8]};
  end

endmodule

// File: rtl/itof_share_ctrl_arb.sv
// One-hot requester arbiter; round-robin with a pointer when ITOF_SHARE_RR_EN is defined,
// otherwise fixed priority (lowest index wins) with no state.
module fcvt_rr_arb
  import fcvt_pkg::*;
#(
  parameter int N = 2
) (
`ifdef ITOF_SHARE_RR_EN
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hs,
`endif
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

`ifdef ITOF_SHARE_RR_EN
  localparam int W = id_w(N);

  logic [W-1:0] ptr;
  logic [W-1:0] gidx;
  logic         found;
  int           idx;

  // search starts one past the last granted requester
  always_comb begin
    grant = '0;
    gidx  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = W'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= W'(N - 1);
    else if (hs)
      ptr <= gidx;
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/itof_share_ctrl.sv
// Two-stage scheduler sharing one itof converter among N_REQ requesters.
// Arbitration mode selected by ITOF_SHARE_RR_EN (round-robin) or fixed priority when undefined.
module itof_share_ctrl
  import fcvt_pkg::*;
#(
  parameter  int N_REQ = 2,
  parameter  int TAG_W = 4,
  localparam int ID_W  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*32-1:0]    req_data,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic [TAG_W-1:0]       resp_tag,
  output logic [1:0]             inflight
);

  typedef struct packed {
    logic [31:0]      data;
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic             s1_v, s2_v;
  res_t             s1, s2;
  res_t             sel;
  logic [31:0]      cvt;
  logic [N_REQ-1:0] grant;
  logic             s1_load, s2_load, hs;

  assign s2_load   = s1_v & (~s2_v | resp_ready);
  assign s1_load   = ~s1_v | s2_load;
  assign req_ready = grant & {N_REQ{s1_load & ~flush & rstn}};
  assign hs        = |(req_valid & req_ready);

  fcvt_rr_arb #(.N(N_REQ)) u_arb (
`ifdef ITOF_SHARE_RR_EN
    .clk   (clk),
    .rst_n (rstn),
    .hs    (hs),
`endif
    .req   (req_valid),
    .grant (grant)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel.data = req_data[i*32 +: 32];
        sel.id   = ID_W'(i);
        sel.tag  = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  itof u_itof (
    .a (s1.data),
    .f (cvt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1   <= '0;
      s2   <= '0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (hs) begin
        s1_v <= 1'b1;
        s1   <= sel;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
      if (s2_load) begin
        s2_v    <= 1'b1;
        s2.data <= cvt;
        s2.id   <= s1.id;
        s2.tag  <= s1.tag;
      end else if (s2_v && resp_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign resp_valid = s2_v;
  assign resp_data  = s2.data;
  assign resp_id    = s2.id;
  assign resp_tag   = s2.tag;
  assign inflight   = {1'b0, s1_v} + {1'b0, s2_v};

endmodule

// File: tb/tb_itof_share_ctrl.sv
// Randomized self-checking bench for itof_share_ctrl against a queue-based reference model.
module tb_itof_share_ctrl;

  localparam int N  = 2;
  localparam int TW = 4;
`ifdef ITOF_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [0:0]      resp_id;
  logic [TW-1:0]   resp_tag;
  logic [1:0]      inflight;

  always #5 clk = ~clk;

  itof_share_ctrl #(.N_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_tag(resp_tag),
    .inflight(inflight)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion: magnitude scaled so the leading one sits at bit 23, excess bits discarded.
  function automatic logic [31:0] m_itof(input logic [31:0] x);
    logic [31:0] mag, man;
    int p;
    if (x == 32'd0) return 32'd0;
    mag = x[31] ? (32'd0 - x) : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    if (p > 23) man = mag >> (p - 23);
    else        man = mag << (23 - p);
    return {x[31], 8'(127 + p), man[22:0]};
  endfunction

  typedef struct {
    logic [31:0]   d;
    int            id;
    logic [TW-1:0] tag;
    bit            vis;
  } ent_t;

  ent_t q[$];
  int   m_ptr;

  logic [N-1:0]  rv;
  logic [31:0]   rd [N];
  logic [TW-1:0] rt [N];

  logic [N-1:0] s_ready;
  logic         s_valid;
  logic [31:0]  s_data;
  logic [1:0]   s_inflight;
  int           last_w;
  bit           cap_en;
  logic [31:0]  cap[$];

  function automatic int winner(input logic [N-1:0] v);
    int idx;
    if (v == '0) return -1;
    for (int k = 0; k < N; k++) begin
      idx = RR ? (m_ptr + 1 + k) % N : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    req_valid = rv;
    for (int i = 0; i < N; i++) begin
      req_data[i*32 +: 32] = rd[i];
      req_tag[i*TW +: TW]  = rt[i];
    end
  endtask

  // One cycle: sample and check just after the inputs settle, then advance the model at the edge.
  task automatic step();
    int nvis, npend, w;
    bit ok, ev, hs;
    logic [N-1:0] er;
    ent_t e;
    drive();
    #1;
    s_ready = req_ready; s_valid = resp_valid; s_data = resp_data; s_inflight = inflight;
    nvis = 0; npend = 0;
    foreach (q[i]) if (q[i].vis) nvis++; else npend++;
    ev = (q.size() > 0) && q[0].vis;
    ok = (npend == 0) || (nvis == 0) || resp_ready;
    w  = winner(rv);
    er = (ok && !flush && w >= 0) ? (N'(1) << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), 32'(ev));
    chk("inflight", 32'(inflight), 32'(q.size()));
    if (ev) begin
      chk("resp_data", resp_data, q[0].d);
      chk("resp_id", 32'(resp_id), 32'(q[0].id));
      chk("resp_tag", 32'(resp_tag), 32'(q[0].tag));
    end
    if (cap_en && resp_valid && resp_ready) cap.push_back(resp_data);
    hs = (er & rv) != '0;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (ev && resp_ready) void'(q.pop_front());
      if (q.size() > 0 && !q[0].vis) q[0].vis = 1'b1;
      if (hs) begin
        e.d = m_itof(rd[w]); e.id = w; e.tag = rt[w]; e.vis = 1'b0;
        q.push_back(e);
      end
    end
    if (hs && RR) m_ptr = w;
    last_w = hs ? w : -1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; flush = 1'b0; rv = '1;
    drive();
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    q.delete();
    m_ptr = N - 1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1; rv = '0;
  endtask

  function automatic logic [31:0] rnd_data();
    logic [31:0] sp [6];
    sp[0] = 32'h0; sp[1] = 32'h80000000; sp[2] = 32'h7FFFFFFF;
    sp[3] = 32'hFFFFFFFF; sp[4] = 32'h1; sp[5] = 32'h01000001;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  logic [31:0] sweep_in  [5];
  logic [31:0] sweep_out [5];
  logic [31:0] bp_out    [3];
  int          vi;

  initial begin
    rstn = 1'b0; flush = 1'b0; resp_ready = 1'b0; rv = '0;
    cap_en = 1'b0; last_w = -1;
    for (int i = 0; i < N; i++) begin rd[i] = '0; rt[i] = '0; end
    drive();
    @(negedge clk);
    do_reset();

    sweep_in[0] = 32'hFFFFFFFF; sweep_out[0] = 32'hBF800000;
    sweep_in[1] = 32'h00000000; sweep_out[1] = 32'h00000000;
    sweep_in[2] = 32'h80000000; sweep_out[2] = 32'hCF000000;
    sweep_in[3] = 32'h7FFFFFFF; sweep_out[3] = 32'h4EFFFFFF;
    sweep_in[4] = 32'h01000001; sweep_out[4] = 32'h4B800000;
    for (int i = 0; i < 5; i++) chk("model_itof", m_itof(sweep_in[i]), sweep_out[i]);
    chk("model_itof_one", m_itof(32'd1), 32'h3F800000);

    // single request
    resp_ready = 1'b1; rv = 2'b01; rd[0] = 32'd1; rt[0] = 4'd3;
    step();
    chk("single_hs", 32'(s_ready), 32'h1);
    rv = '0;
    step(); chk("single_infl1", 32'(s_inflight), 32'd1);
    step(); chk("single_infl2", 32'(s_inflight), 32'd1);
    chk("single_data", s_data, 32'h3F800000);
    step(); chk("single_infl3", 32'(s_inflight), 32'd0);

    // value sweep, one per cycle
    cap.delete(); cap_en = 1'b1; rv = 2'b01;
    for (int i = 0; i < 5; i++) begin
      rd[0] = sweep_in[i]; rt[0] = TW'(i);
      step();
    end
    rv = '0;
    repeat (3) step();
    cap_en = 1'b0;
    chk("sweep_count", 32'(cap.size()), 32'd5);
    for (int i = 0; i < 5 && i < cap.size(); i++) chk("sweep_data", cap[i], sweep_out[i]);

    // contention
    do_reset();
    resp_ready = 1'b1; rv = 2'b11; rd[0] = 32'd10; rd[1] = 32'd20; rt[0] = 4'd1; rt[1] = 4'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("contention_grant", 32'(s_ready), RR ? ((k % 2 == 1) ? 32'd2 : 32'd1) : 32'd1);
    end
    rv = '0;
    repeat (3) step();

    // backpressure
    cap.delete(); cap_en = 1'b1; resp_ready = 1'b0; rv = 2'b01; vi = 1;
    rd[0] = 32'd1; rt[0] = 4'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (last_w == 0) begin vi++; rd[0] = 32'(vi); rt[0] = TW'(vi); if (vi > 3) rv = '0; end
    end
    chk("bp_inflight", 32'(s_inflight), 32'd2);
    chk("bp_ready", 32'(s_ready), 32'd0);
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (last_w == 0) begin vi++; rd[0] = 32'(vi); if (vi > 3) rv = '0; end
    end
    cap_en = 1'b0;
    bp_out[0] = 32'h3F800000; bp_out[1] = 32'h40000000; bp_out[2] = 32'h40400000;
    chk("bp_count", 32'(cap.size()), 32'd3);
    for (int i = 0; i < 3 && i < cap.size(); i++) chk("bp_order", cap[i], bp_out[i]);

    // flush with both stages full
    resp_ready = 1'b0; rv = 2'b01; rd[0] = 32'd5;
    for (int k = 0; k < 3; k++) begin
      step();
      if (last_w == 0) rd[0] = rd[0] + 32'd1;
    end
    flush = 1'b1;
    step();
    chk("flush_inflight", 32'(s_inflight), 32'd2);
    chk("flush_ready", 32'(s_ready), 32'd0);
    flush = 1'b0;
    step();
    chk("post_flush_valid", 32'(s_valid), 32'd0);
    chk("post_flush_inflight", 32'(s_inflight), 32'd0);
    chk("post_flush_accept", 32'(s_ready), 32'd1);
    rv = '0; resp_ready = 1'b1;
    repeat (3) step();

    // reset mid-stream, then first grant
    rv = 2'b11;
    step(); step();
    do_reset();
    rv = 2'b11;
    step();
    chk("first_grant", 32'(s_ready), 32'd1);
    rv = '0;
    repeat (3) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1; rd[i] = rnd_data(); rt[i] = TW'($urandom);
        end
      end
      resp_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      if (c == 1500) do_reset();
      step();
      if (last_w >= 0) rv[last_w] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
